// File: rtl/result_mem_arbiter_pkg.sv
// Shared definitions for the result-memory arbiter: geometry, issue-stage
// state encoding and the debug view exported by the top.
package result_mem_pkg;

  localparam int ADDR_WIDTH_4MEM = 14;
  localparam int DATA_WIDTH      = 32;
  localparam int BANK_SEL_W      = 2;

  // Requester slots used on the two-way arbiter.
  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;

  // Issue-stage state equals the access currently driven on the memory.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } issue_state_e;

  // Debug view: FSM state, round-robin history, bank of the driven address
  // and the read-valid pipeline contents.
  typedef struct packed {
    issue_state_e           state;
    logic                   last_rd;
    logic [BANK_SEL_W-1:0]  bank;
    logic [1:0]             rd_pipe;
  } dbg_t;

endpackage

// File: rtl/result_mem_arbiter_if.sv
// Bundle of the writer, host and memory-side signals of the arbiter.
//
// Handshake: wr_req/rd_req are raised with their address (and data) and held
// stable until the matching one-cycle wr_gnt/rd_gnt pulse; the request is
// accepted in the cycle the grant is high. rd_valid qualifies rd_data for a
// single cycle, two cycles after rd_gnt. There is no back-pressure on rd_valid.
interface result_mem_if #(
  parameter int ADDR_WIDTH_4MEM = result_mem_pkg::ADDR_WIDTH_4MEM,
  parameter int DATA_WIDTH      = result_mem_pkg::DATA_WIDTH
);

  logic                       wr_req;
  logic [ADDR_WIDTH_4MEM-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic                       wr_gnt;

  logic                       rd_req;
  logic [ADDR_WIDTH_4MEM-1:0] rd_addr;
  logic                       rd_gnt;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic                       rd_valid;

  logic                       host_mode;

  logic [ADDR_WIDTH_4MEM-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic                       mem_wen;
  logic                       mem_cen_sel;
  logic                       mem_addr_sel;
  logic [DATA_WIDTH-1:0]      mem_q;

  // Arbiter side.
  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, host_mode, mem_q,
    output wr_gnt, rd_gnt, rd_data, rd_valid,
           mem_addr, mem_wdata, mem_wen, mem_cen_sel, mem_addr_sel
  );

  // Requesters and bank controller side.
  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, host_mode, mem_q,
    input  wr_gnt, rd_gnt, rd_data, rd_valid,
           mem_addr, mem_wdata, mem_wen, mem_cen_sel, mem_addr_sel
  );

endinterface

// File: rtl/result_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester wins immediately; on a tie the
// requester that did not win last time wins. History moves only on a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       last_rd
);

  // 1 when slot 1 (read) won the most recent grant; reset gives slot 0 the first tie.
  logic r_last_rd;

  // Grant: slot 0 wins unless slot 1 also asks and slot 0 won last time.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | r_last_rd);
    gnt[1] = req[1] & (~req[0] | ~r_last_rd);
  end

  // History update, only on a cycle that actually grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_rd <= 1'b1;
    end else if (upd) begin
      r_last_rd <= gnt[1];
    end
  end

  assign last_rd = r_last_rd;

endmodule

// File: rtl/result_mem_arbiter.sv
// Arbitrates the pipeline writer and the host reader onto a single
// four-bank result memory. Grants are combinational; the granted access is
// registered onto the memory bus the next cycle, and read data returns two
// cycles after the grant.
module result_mem_arbiter #(
  parameter int ADDR_WIDTH_4MEM = result_mem_pkg::ADDR_WIDTH_4MEM,
  parameter int DATA_WIDTH      = result_mem_pkg::DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  result_mem_if.slave         bus,
  output result_mem_pkg::dbg_t o_dbg
);

  import result_mem_pkg::*;

  // Arbitration
  logic [1:0]                 w_req;
  logic [1:0]                 w_gnt;
  logic                       w_upd;
  logic                       w_last_rd;

  // Issue-stage FSM
  issue_state_e               r_state;
  issue_state_e               w_state_nxt;
  logic                       w_mem_wen;
  logic                       w_mem_cen_sel;

  // Memory-side registers
  logic [ADDR_WIDTH_4MEM-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0]      r_mem_wdata;
  logic                       r_addr_sel;
  logic [1:0]                 r_rd_pipe;

  // Eligibility: host mode fences the writer; nothing is granted in reset.
  always_comb begin
    w_req         = 2'b00;
    w_req[REQ_WR] = bus.wr_req & ~bus.host_mode & rst_n;
    w_req[REQ_RD] = bus.rd_req & rst_n;
  end

  assign w_upd = |w_gnt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_req),
    .upd     (w_upd),
    .gnt     (w_gnt),
    .last_rd (w_last_rd)
  );

  assign bus.wr_gnt = w_gnt[REQ_WR];
  assign bus.rd_gnt = w_gnt[REQ_RD];

  // FSM state register: holds the access being driven on the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: set purely by this cycle's grant.
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_gnt[REQ_WR]) begin
      w_state_nxt = ST_WRITE;
    end else if (w_gnt[REQ_RD]) begin
      w_state_nxt = ST_READ;
    end
  end

  // FSM outputs: chip-enable for any access, write-enable only for writes.
  always_comb begin
    w_mem_wen     = 1'b0;
    w_mem_cen_sel = 1'b0;
    case (r_state)
      ST_WRITE: begin
        w_mem_wen     = 1'b1;
        w_mem_cen_sel = 1'b1;
      end
      ST_READ: begin
        w_mem_cen_sel = 1'b1;
      end
      default: begin
        w_mem_wen     = 1'b0;
        w_mem_cen_sel = 1'b0;
      end
    endcase
  end

  // Address/data capture on a grant; both hold when nothing is granted.
  // Write data is only reloaded by writes, so a read leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_gnt[REQ_WR]) begin
      r_mem_addr  <= bus.wr_addr;
      r_mem_wdata <= bus.wr_data;
    end else if (w_gnt[REQ_RD]) begin
      r_mem_addr  <= bus.rd_addr;
    end
  end

  // Ownership flag follows host_mode, but never switches under a live write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_sel <= 1'b1;
    end else if (r_state != ST_WRITE) begin
      r_addr_sel <= ~bus.host_mode;
    end
  end

  // Read-valid pipeline: stage 0 is the address cycle, stage 1 the data cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pipe <= 2'b00;
    end else begin
      r_rd_pipe <= {r_rd_pipe[0], w_gnt[REQ_RD]};
    end
  end

  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_wen      = w_mem_wen;
  assign bus.mem_cen_sel  = w_mem_cen_sel;
  assign bus.mem_addr_sel = r_addr_sel;
  assign bus.rd_valid     = r_rd_pipe[1];
  assign bus.rd_data      = bus.mem_q;

  // Debug view of internal state.
  always_comb begin
    o_dbg         = '0;
    o_dbg.state   = r_state;
    o_dbg.last_rd = w_last_rd;
    o_dbg.bank    = r_mem_addr[ADDR_WIDTH_4MEM-1 -: BANK_SEL_W];
    o_dbg.rd_pipe = r_rd_pipe;
  end

endmodule

// File: tb/tb_result_mem_arbiter.sv
// Bench for result_mem_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model and a read-data scoreboard.
module tb_result_mem_arbiter;
  import result_mem_pkg::*;

  localparam int AW    = ADDR_WIDTH_4MEM;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  result_mem_if #(.ADDR_WIDTH_4MEM(AW), .DATA_WIDTH(DW)) bus ();
  dbg_t dbg;

  result_mem_arbiter #(.ADDR_WIDTH_4MEM(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .o_dbg (dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- bank model (environment) ----------------
  logic [DW-1:0] bank    [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(32'hA5A5_0000 ^ (a * 32'h9E37_79B1));
  endfunction

  // Banks answer one cycle after the address is presented.
  always @(posedge clk) begin
    if (bus.mem_cen_sel === 1'b1) begin
      if (bus.mem_wen) bank[bus.mem_addr] <= bus.mem_wdata;
      else             bus.mem_q <= bank[bus.mem_addr];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            due_q[$];
  bit            m_last_rd;
  bit            m_addr_sel;
  bit            m_write_live;
  bit            m_acc_v;
  bit            m_acc_w;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_flags"}, {bus.wr_gnt, bus.rd_gnt, bus.rd_valid, bus.mem_wen,
                          bus.mem_cen_sel, bus.mem_addr_sel}, 6'b000001);
    chk({tag, "_addr"},  bus.mem_addr, '0);
    chk({tag, "_wdata"}, bus.mem_wdata, '0);
    chk({tag, "_state"}, dbg.state, ST_IDLE);
    chk({tag, "_last"},  dbg.last_rd, 1'b1);
  endtask

  // Monitor: every cycle compare the DUT against the model, then advance it.
  always @(negedge clk) begin
    bit ew, er, new_sel;
    if (!rst_n) begin
      chk_reset_vals("rst_mon");
      exp_q.delete();
      due_q.delete();
      m_last_rd    = 1'b1;
      m_addr_sel   = 1'b1;
      m_write_live = 1'b0;
      m_acc_v      = 1'b0;
      m_acc_w      = 1'b0;
      m_addr       = '0;
      m_wdata      = '0;
    end else begin
      ew = bus.wr_req && !bus.host_mode;
      er = bus.rd_req;
      if (ew && er) begin
        if (m_last_rd) er = 1'b0;
        else           ew = 1'b0;
      end
      chk("grant", {bus.wr_gnt, bus.rd_gnt}, {ew, er});
      chk("addr_sel", bus.mem_addr_sel, m_addr_sel);
      chk("mem_cen", bus.mem_cen_sel, m_acc_v);
      chk("mem_wen", bus.mem_wen, m_acc_v & m_acc_w);
      chk("mem_addr", bus.mem_addr, m_addr);
      if (m_acc_v && m_acc_w) chk("mem_wdata", bus.mem_wdata, m_wdata);

      if (bus.rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_unexpected", 1'b1, 1'b0);
        end else begin
          chk("rd_data", bus.rd_data, exp_q.pop_front());
          chk("rd_latency", cyc, due_q.pop_front());
        end
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        chk("rd_valid_missing", 1'b0, 1'b1);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end

      // Ownership follows host_mode except while a write occupies the memory.
      new_sel      = m_write_live ? m_addr_sel : !bus.host_mode;
      m_addr_sel   = new_sel;
      m_write_live = ew;
      m_acc_v      = ew || er;
      m_acc_w      = ew;
      if (ew) begin
        m_addr            = bus.wr_addr;
        m_wdata           = bus.wr_data;
        ref_mem[bus.wr_addr] = bus.wr_data;
        m_last_rd         = 1'b0;
      end
      if (er) begin
        m_addr = bus.rd_addr;
        exp_q.push_back(ref_mem[bus.rd_addr]);
        due_q.push_back(cyc + 2);
        m_last_rd = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(input bit is_wr, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (is_wr ? bus.wr_gnt : bus.rd_gnt) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_gnt_seen"}, ok, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset_async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    wait_gnt(1'b1, "wr");
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("wr_mem_addr", bus.mem_addr, a);
    chk("wr_mem_wdata", bus.mem_wdata, d);
    chk("wr_mem_ctl", {bus.mem_wen, bus.mem_cen_sel}, 2'b11);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    wait_gnt(1'b0, "rd");
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("rd_valid_early", bus.rd_valid, 1'b0);
    @(negedge clk);
    chk("rd_valid_t2", bus.rd_valid, 1'b1);
    chk("rd_data_t2", bus.rd_data, d);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] b2b_addr [4];
    logic [6:0]    vseen;
    bit            wg, rg;

    bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 0; bus.rd_addr = '0; bus.host_mode = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bank[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    bank[14'h3FFF]    = 32'h1234_5678;
    ref_mem[14'h3FFF] = 32'h1234_5678;

    // Initial reset.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset_init");
    rst_n = 1'b1;
    idle(1);

    // Single write, then single read at the top of the address space.
    do_write(14'h1005, 32'hDEAD_BEEF);
    idle(2);
    do_read(14'h3FFF, 32'h1234_5678);
    idle(2);

    // Both requesting right after reset: writer wins the first tie, then alternate.
    apply_reset();
    bus.wr_req = 1; bus.wr_addr = 14'h0100; bus.wr_data = $urandom;
    bus.rd_req = 1; bus.rd_addr = 14'h0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("tie_seq", {bus.wr_gnt, bus.rd_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      bus.wr_data = $urandom;
    end
    bus.wr_req = 0; bus.rd_req = 0;
    idle(3);

    // Host mode: only reads are granted and the pipeline gives up the memory.
    bus.host_mode = 1;
    bus.wr_req = 1; bus.wr_addr = 14'h2222; bus.wr_data = 32'hCAFE_F00D;
    bus.rd_req = 1; bus.rd_addr = 14'h2222;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("host_wr_gnt", bus.wr_gnt, 1'b0);
      chk("host_rd_gnt", bus.rd_gnt, 1'b1);
      @(posedge clk); #1;
      bus.rd_addr = AW'($urandom_range(0, DEPTH - 1));
    end
    @(negedge clk);
    chk("host_addr_sel", bus.mem_addr_sel, 1'b0);
    @(posedge clk); #1;
    bus.rd_req = 0;
    bus.host_mode = 0;
    wait_gnt(1'b1, "host_release_wr");
    @(posedge clk); #1;
    bus.wr_req = 0;
    idle(3);

    // Reset the cycle after a read grant: the read must vanish.
    bus.rd_req = 1; bus.rd_addr = 14'h0ABC;
    wait_gnt(1'b0, "rst_rd");
    @(posedge clk); #1;
    bus.rd_req = 0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset_inflight");
    bus.wr_req = 1; bus.rd_req = 1;
    #1;
    chk("reset_gnt_gated", {bus.wr_gnt, bus.rd_gnt}, 2'b00);
    bus.wr_req = 0; bus.rd_req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_rd_valid", bus.rd_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Back-to-back reads across all four banks.
    b2b_addr[0] = 14'h0000; b2b_addr[1] = 14'h1000;
    b2b_addr[2] = 14'h2000; b2b_addr[3] = 14'h3000;
    vseen = '0;
    bus.rd_req = 1; bus.rd_addr = b2b_addr[0];
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      vseen[i] = bus.rd_valid;
      if (i < 4) chk("b2b_gnt", bus.rd_gnt, 1'b1);
      @(posedge clk); #1;
      if (i < 3) bus.rd_addr = b2b_addr[i + 1];
      else       bus.rd_req  = 1'b0;
    end
    chk("b2b_valid_train", vseen, 7'b0111100);
    idle(2);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      wg = bus.wr_gnt;
      rg = bus.rd_gnt;
      @(posedge clk); #1;
      if (wg) bus.wr_req = 1'b0;
      if (rg) bus.rd_req = 1'b0;
      if (!bus.wr_req && $urandom_range(0, 3) != 0) begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = {2'($urandom_range(0, 3)), (AW-2)'($urandom_range(0, 15))};
        bus.wr_data = $urandom;
      end
      if (!bus.rd_req && $urandom_range(0, 2) != 0) begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = {2'($urandom_range(0, 3)), (AW-2)'($urandom_range(0, 15))};
      end
      if ($urandom_range(0, 15) == 0) bus.host_mode = ~bus.host_mode;
    end

    // Drain: let pending grants land, then expect an empty scoreboard.
    bus.host_mode = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      wg = bus.wr_gnt;
      rg = bus.rd_gnt;
      @(posedge clk); #1;
      if (wg) bus.wr_req = 1'b0;
      if (rg) bus.rd_req = 1'b0;
    end
    idle(4);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", {bus.wr_req, bus.rd_req}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
